// File: rtl/multicycle_control_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multicycle datapath controller.
//   state_t     - FSM state encoding (JUMP present only with MULTICYCLE_CONTROL_JUMP_EN)
//   OP_*        - instruction opcodes recognised in DECODE
//   ALU_*       - 3-bit ALUOp codes (zero-extended at the top-level port)
//   ctrl_t      - per-state Moore control bundle
//   state_ctrl  - maps a state (and opcode, for immediate ops) to its control bundle
// Configuration macro: MULTICYCLE_CONTROL_JUMP_EN adds the JUMP state.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_IMM_EXEC = 4'd10,
        S_IMM_WB   = 4'd11
`ifdef MULTICYCLE_CONTROL_JUMP_EN
        , S_JUMP   = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SLTI  = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_ADDI  = 3'b011;
    localparam logic [2:0] ALU_ORI   = 3'b101;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_ANDI  = 3'b111;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic [2:0] imm_aluop(input logic [5:0] op);
        logic [2:0] a;
        case (op)
            OP_ANDI: a = ALU_ANDI;
            OP_ORI:  a = ALU_ORI;
            OP_SLTI: a = ALU_SLTI;
            default: a = ALU_ADDI;
        endcase
        return a;
    endfunction

    function automatic ctrl_t state_ctrl(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_RTYPE;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_IMM_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = imm_aluop(op);
            end
            S_IMM_WB: begin
                c.reg_write = 1'b1;
            end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
`endif
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// mc_wait_timer: counts consecutive cycles a memory-wait state goes without
// mem_ready and flags the cycle in which the limit of 2^W-1 cycles is reached.
//   clk, rst_n  - clock, async active-low reset
//   active      - FSM is in a memory-wait state (FETCH, MEM_RD, MEM_WR)
//   mem_ready   - memory completed the access this cycle
//   timeout     - this cycle is the limit cycle and memory is still not ready
module mc_wait_timer #(
    parameter int W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);
    // Count value seen in the limit cycle: the miss in that cycle would be
    // the (2^W-1)th, so ready there still counts as success.
    localparam logic [W-1:0] LAST = W'((32'd1 << W) - 32'd2);

    logic [W-1:0] count;

    assign timeout = active && !mem_ready && (count == LAST);

    // Every exit from a wait state happens on ready or timeout, so clearing
    // there (and whenever idle) guarantees each wait state is entered at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!active || mem_ready || timeout) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle MIPS-style datapath.
//   clk, rst_n     - clock, async active-low reset
//   en             - allows leaving IDLE / chaining into the next FETCH
//   OPCODE         - instruction opcode, valid from DECODE onward
//   mem_ready      - memory access finished this cycle
//   PCWrite .. ALUOp - datapath controls (registered per state; IRWrite and the
//                    FETCH PCWrite are qualified by mem_ready)
//   instr_done     - pulse on the final cycle of an instruction
//   illegal_op     - pulse in DECODE on an unknown opcode
//   mem_err        - sticky, set on a memory-wait timeout
// Configuration macro: MULTICYCLE_CONTROL_JUMP_EN enables the j instruction.
//
// state      | meaning
// IDLE       | waiting for en
// FETCH      | instruction read, PC+4 computed; waits for mem_ready
// DECODE     | register read, branch target computed, opcode dispatch
// MEM_ADDR   | lw/sw effective address
// MEM_RD     | data read; waits for mem_ready
// MEM_WB     | load result to rt
// MEM_WR     | data write; waits for mem_ready
// R_EXEC     | R-type ALU operation
// R_WB       | R-type result to rd
// BRANCH     | beq compare and conditional PC update
// IMM_EXEC   | immediate ALU operation
// IMM_WB     | immediate result to rt
// JUMP       | unconditional PC update (macro only)
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W   = 3,
    parameter int TIMEOUT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [5:0]         OPCODE,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               instr_done,
    output logic               illegal_op,
    output logic               mem_err
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl_q;
    logic   in_wait;
    logic   timeout;
    logic   fetch_done;
    logic   done_c;
    logic   illegal_c;

    assign in_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

    mc_wait_timer #(
        .W (TIMEOUT_W)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (in_wait),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_comb begin
        state_nxt = state;
        done_c    = 1'b0;
        illegal_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready)    state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_IDLE;
            end
            S_DECODE: begin
                case (OPCODE)
                    OP_RTYPE:                         state_nxt = S_R_EXEC;
                    OP_LW, OP_SW:                     state_nxt = S_MEM_ADDR;
                    OP_BEQ:                           state_nxt = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_nxt = S_IMM_EXEC;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
                    OP_J:                             state_nxt = S_JUMP;
`endif
                    default: begin
                        state_nxt = S_IDLE;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                state_nxt = (OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                if (mem_ready)    state_nxt = S_MEM_WB;
                else if (timeout) state_nxt = S_IDLE;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    done_c    = 1'b1;
                    state_nxt = en ? S_FETCH : S_IDLE;
                end else if (timeout) begin
                    state_nxt = S_IDLE;
                end
            end
            S_R_EXEC:   state_nxt = S_R_WB;
            S_IMM_EXEC: state_nxt = S_IMM_WB;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
            S_JUMP,
`endif
            S_MEM_WB, S_R_WB, S_BRANCH, S_IMM_WB: begin
                done_c    = 1'b1;
                state_nxt = en ? S_FETCH : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Controls are registered from the next state so each output is a pure
    // function of the state being entered; reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ctrl_q  <= CTRL_IDLE;
            mem_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            ctrl_q <= state_ctrl(state_nxt, OPCODE);
            if (timeout) mem_err <= 1'b1;
        end
    end

    // The instruction register and PC+4 are only committed once the fetch
    // actually returns data, so a fetch timeout writes nothing.
    assign fetch_done = (state == S_FETCH) && mem_ready;

    assign PCWrite     = ctrl_q.pc_write | fetch_done;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign IRWrite     = fetch_done;
    assign MemToReg    = ctrl_q.mem_to_reg;
    assign RegDst      = ctrl_q.reg_dst;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign PCSource    = ctrl_q.pc_source;
    assign ALUOp       = ALUOP_W'(ctrl_q.alu_op);
    assign instr_done  = done_c;
    assign illegal_op  = illegal_c;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int ALUOP_W   = 4;
    localparam int TIMEOUT_W = 2;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_JMP  = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,ALUSrcA}
    //  _ALUSrcB _PCSource _ALUOp _{instr_done,illegal_op}
    localparam logic [19:0] V_IDLE      = 20'b0000000000_00_00_0000_00;
    localparam logic [19:0] V_FETCH_W   = 20'b0001000000_01_00_0000_00;
    localparam logic [19:0] V_FETCH_RDY = 20'b1001010000_01_00_0000_00;
    localparam logic [19:0] V_DECODE    = 20'b0000000000_11_00_0000_00;
    localparam logic [19:0] V_DEC_ILL   = 20'b0000000000_11_00_0000_01;
    localparam logic [19:0] V_R_EXEC    = 20'b0000000001_00_00_0010_00;
    localparam logic [19:0] V_R_WB      = 20'b0000000110_00_00_0000_10;
    localparam logic [19:0] V_MEM_ADDR  = 20'b0000000001_10_00_0000_00;
    localparam logic [19:0] V_MEM_RD    = 20'b0011000000_00_00_0000_00;
    localparam logic [19:0] V_MEM_WB    = 20'b0000001010_00_00_0000_10;
    localparam logic [19:0] V_MEM_WR_W  = 20'b0010100000_00_00_0000_00;
    localparam logic [19:0] V_MEM_WR_D  = 20'b0010100000_00_00_0000_10;
    localparam logic [19:0] V_BRANCH    = 20'b0100000001_00_01_0110_10;
    localparam logic [19:0] V_IMM_BASE  = 20'b0000000001_10_00_0000_00;
    localparam logic [19:0] V_IMM_WB    = 20'b0000000010_00_00_0000_10;
    localparam logic [19:0] V_JUMP      = 20'b1000000000_00_10_0000_10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic mem_ready = 1'b0;
    logic [5:0] opcode = 6'b0;

    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic MemToReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [ALUOP_W-1:0] ALUOp;
    logic instr_done, illegal_op, mem_err;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .ALUOP_W   (ALUOP_W),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .OPCODE      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemToReg    (MemToReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .mem_err     (mem_err)
    );

    wire [19:0] ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
                       ALUOp, instr_done, illegal_op};

    // Cycle convention: tasks begin at posedge+1, set inputs, sample at posedge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; mem_ready = 1'b1; opcode = OP_R;
        #2;
        total++;
        if (ctl !== V_IDLE) $display("FAIL reset_outputs: got %b want %b", ctl, V_IDLE);
        else passed++;
        total++;
        if (mem_err !== 1'b0) $display("FAIL reset_mem_err: got %b want 0", mem_err);
        else passed++;
        tick();
        en = 1'b0; mem_ready = 1'b0; rst_n = 1'b1;
        tick();
        #1;
        total++;
        if (ctl !== V_IDLE) $display("FAIL idle_hold: got %b want %b", ctl, V_IDLE);
        else passed++;
        tick();
    endtask

    task automatic test_rtype();
        logic [19:0] exp [4];
        exp = '{V_FETCH_RDY, V_DECODE, V_R_EXEC, V_R_WB};
        en = 1'b1; mem_ready = 1'b1; opcode = OP_R;
        tick();
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (ctl !== exp[i]) $display("FAIL rtype cycle %0d: got %b want %b", i + 1, ctl, exp[i]);
            else passed++;
            tick();
        end
        #1;
        total++;
        if (ctl !== V_IDLE) $display("FAIL rtype_idle: got %b want %b", ctl, V_IDLE);
        else passed++;
        tick();
    endtask

    task automatic test_lw_wait();
        logic [19:0] exp [7];
        logic        rdy [7];
        exp = '{V_FETCH_RDY, V_DECODE, V_MEM_ADDR, V_MEM_RD, V_MEM_RD, V_MEM_RD, V_MEM_WB};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        en = 1'b1; opcode = OP_LW;
        tick();
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            #1;
            total++;
            if (ctl !== exp[i]) $display("FAIL lw cycle %0d: got %b want %b", i + 1, ctl, exp[i]);
            else passed++;
            tick();
        end
        mem_ready = 1'b0;
        #1;
        total++;
        if (ctl !== V_IDLE) $display("FAIL lw_idle: got %b want %b", ctl, V_IDLE);
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp [8];
        logic        rdy [8];
        logic        enb [8];
        logic [5:0]  ops [8];
        exp = '{V_FETCH_RDY, V_DECODE, V_MEM_ADDR, V_MEM_WR_W, V_MEM_WR_D,
                V_FETCH_RDY, V_DECODE, V_BRANCH};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        enb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ops = '{OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_BEQ, OP_BEQ, OP_BEQ};
        en = 1'b1; opcode = OP_SW;
        tick();
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i]; en = enb[i]; opcode = ops[i];
            #1;
            total++;
            if (ctl !== exp[i]) $display("FAIL sw_beq cycle %0d: got %b want %b", i + 1, ctl, exp[i]);
            else passed++;
            tick();
        end
        mem_ready = 1'b0;
        #1;
        total++;
        if (ctl !== V_IDLE) $display("FAIL sw_beq_idle: got %b want %b", ctl, V_IDLE);
        else passed++;
        tick();
    endtask

    task automatic test_imm();
        logic [5:0]  ops  [4];
        logic [3:0]  aops [4];
        logic [19:0] exp  [4];
        ops  = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
        aops = '{4'b0011, 4'b0111, 4'b0101, 4'b0001};
        for (int k = 0; k < 4; k++) begin
            exp = '{V_FETCH_RDY, V_DECODE, V_IMM_BASE | {14'd0, aops[k], 2'd0}, V_IMM_WB};
            en = 1'b1; mem_ready = 1'b1; opcode = ops[k];
            tick();
            en = 1'b0;
            for (int i = 0; i < 4; i++) begin
                #1;
                total++;
                if (ctl !== exp[i])
                    $display("FAIL imm op %b cycle %0d: got %b want %b", ops[k], i + 1, ctl, exp[i]);
                else passed++;
                tick();
            end
        end
        #1;
        total++;
        if (ctl !== V_IDLE) $display("FAIL imm_idle: got %b want %b", ctl, V_IDLE);
        else passed++;
        tick();
    endtask

    task automatic test_illegal();
        logic [19:0] exp [3];
        exp = '{V_FETCH_RDY, V_DEC_ILL, V_IDLE};
        en = 1'b1; mem_ready = 1'b1; opcode = OP_BAD;
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ctl !== exp[i]) $display("FAIL illegal cycle %0d: got %b want %b", i + 1, ctl, exp[i]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_jump();
        logic [19:0] exp [4];
        int n;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
        exp = '{V_FETCH_RDY, V_DECODE, V_JUMP, V_IDLE};
        n = 4;
`else
        exp = '{V_FETCH_RDY, V_DEC_ILL, V_IDLE, V_IDLE};
        n = 3;
`endif
        en = 1'b1; mem_ready = 1'b1; opcode = OP_JMP;
        tick();
        en = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            total++;
            if (ctl !== exp[i]) $display("FAIL jump cycle %0d: got %b want %b", i + 1, ctl, exp[i]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_limit_success();
        logic [19:0] exp [6];
        logic        rdy [6];
        exp = '{V_FETCH_W, V_FETCH_W, V_FETCH_RDY, V_DECODE, V_BRANCH, V_IDLE};
        rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        en = 1'b1; opcode = OP_BEQ;
        tick();
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i];
            #1;
            total++;
            if (ctl !== exp[i]) $display("FAIL limit_ready cycle %0d: got %b want %b", i + 1, ctl, exp[i]);
            else passed++;
            tick();
        end
        total++;
        if (mem_err !== 1'b0) $display("FAIL limit_ready_mem_err: got %b want 0", mem_err);
        else passed++;
    endtask

    task automatic test_timeout();
        logic [19:0] exp  [5];
        logic        merr [5];
        exp  = '{V_FETCH_W, V_FETCH_W, V_FETCH_W, V_IDLE, V_IDLE};
        merr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        en = 1'b1; mem_ready = 1'b0; opcode = OP_R;
        tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (ctl !== exp[i]) $display("FAIL timeout cycle %0d: got %b want %b", i + 1, ctl, exp[i]);
            else passed++;
            total++;
            if (mem_err !== merr[i]) $display("FAIL timeout_mem_err cycle %0d: got %b want %b", i + 1, mem_err, merr[i]);
            else passed++;
            tick();
        end
        repeat (4) tick();
        #1;
        total++;
        if (mem_err !== 1'b1) $display("FAIL mem_err_sticky: got %b want 1", mem_err);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_err !== 1'b0) $display("FAIL mem_err_reset: got %b want 0", mem_err);
        else passed++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_write();
        logic [19:0] exp [4];
        logic        rdy [4];
        exp = '{V_FETCH_RDY, V_DECODE, V_MEM_ADDR, V_MEM_WR_W};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0};
        en = 1'b1; opcode = OP_SW;
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = rdy[i];
            #1;
            total++;
            if (ctl !== exp[i]) $display("FAIL sw_reset cycle %0d: got %b want %b", i + 1, ctl, exp[i]);
            else passed++;
            if (i < 3) tick();
        end
        // Still mid-MEM_WR, between clock edges.
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        total++;
        if (MemWrite !== 1'b0) $display("FAIL async_memwrite: got %b want 0", MemWrite);
        else passed++;
        total++;
        if (ctl !== V_IDLE) $display("FAIL async_outputs: got %b want %b", ctl, V_IDLE);
        else passed++;
        tick();
        rst_n = 1'b1; en = 1'b0; mem_ready = 1'b0;
        #1;
        total++;
        if (ctl !== V_IDLE) $display("FAIL post_reset_idle: got %b want %b", ctl, V_IDLE);
        else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back();
        test_imm();
        test_illegal();
        test_jump();
        test_limit_success();
        test_timeout();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
